block_interleaver_stream: RTL
=============================

Name: block_interleaver_stream

Overview:
- Streaming, parametrised successor to the fixed 44-bit combinational bit interleaver in the Hybrid Hamming datapath.
- Accepts symbols serially over a valid/ready handshake into a ROWS x COLS matrix, then emits them in transposed order.
- Two ping-pong banks sustain one symbol per clock.
- Runtime mode selects interleave or deinterleave, so one block serves both the TX and RX sides of the codec chain.

Parameters:
- ROWS, 4, matrix rows (depth of the interleave), >=2
- COLS, 11, matrix columns, >=2
- SYM_W, 1, bits per symbol (1 = bit interleaving, matches 44-bit codeword case)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = interleave, 1 = deinterleave; sampled on first accepted symbol of each block
- in_valid  in  1  input symbol valid
- in_ready  out  1  block can accept a symbol
- in_data  in  SYM_W  input symbol
- out_valid  out  1  output symbol valid
- out_ready  in  1  downstream accepts symbol
- out_data  out  SYM_W  output symbol
- out_last  out  1  high with the final symbol of each block
- out_mode  out  1  mode the current output block was captured with

Behaviour:
- Block size N = ROWS*COLS symbols.
- Input arrival index k = 0..N-1. Output index j = 0..N-1.
- Interleave (mode 0): output j carries input index (j mod ROWS)*COLS + (j div ROWS).
  - Column-major read of a row-major fill.
  - ROWS=4, COLS=11 gives 0, 11, 22, 33, 1, 12, ...
- Deinterleave (mode 1): output j carries input index (j mod COLS)*ROWS + (j div COLS).
  - This is the exact inverse, so deint(int(x)) = x.
- Address generation uses row/col counters only; no divide or multiply by non-constant values at runtime.
- Storage: two banks of N x SYM_W, with per-bank full flag and per-bank captured mode.
  - Memory is asynchronous-read and is not reset.
- Writer:
  - in_ready = !full[wr_sel].
  - A transfer occurs on in_valid & in_ready and writes sequential address k.
  - On k = 0, mode is captured into bank_mode[wr_sel].
  - On k = N-1: set full[wr_sel], toggle wr_sel, clear k.
- Reader:
  - out_valid = full[rd_sel].
  - out_data = bank[rd_sel][perm(j)]; out_mode = bank_mode[rd_sel].
  - A transfer occurs on out_valid & out_ready; j advances.
  - out_last = out_valid & (j == N-1).
  - On the last transfer: clear full[rd_sel], toggle rd_sel, clear j.
- Latency: out_valid rises in the cycle after the edge that accepted input symbol N-1. Steady-state throughput is 1 symbol/clk with out_ready held high.
- Output stability: out_data/out_valid are held while out_valid & !out_ready.
- Simultaneous events:
  - Write into one bank and read from the other in the same cycle is legal.
  - If the reader frees bank B on the same edge the writer fills bank A, in_ready (for B) is high the next cycle.
  - Full set and clear never target the same bank in the same cycle.
- Back-pressure: with both banks full, in_ready = 0 until the reader completes a block.
- Mode changes mid-block are ignored; they take effect at the next block's first symbol.
- Reset (any time, including mid-block):
  - in_ready = 1, out_valid = 0, out_last = 0, out_mode = 0.
  - All counters and flags clear; wr_sel = rd_sel = 0.
  - Partial blocks are discarded.
  - out_data is don't-care while out_valid = 0.

Decomposition:
- Package interleaver_pkg holds:
  - mode constants MODE_INT = 1'b0, MODE_DEINT = 1'b1;
  - a localparam helper for N;
  - a reference permutation function perm_idx(j, rows, cols, mode) for the bench scoreboard.
- Sub-module il_addr_gen: a row/col wrap counter pair with enable, clear, and swap-dims input. It produces the linear read address and a last flag, and is instantiated once for the read side. The write side uses a plain counter.

Test Plan:
- Interleave, defaults with SYM_W=8: inputs 0..43 back-to-back, mode 0 -> outputs 0,11,22,33,1,12,...,10,21,32,43; out_last only on 43; first out_valid 1 cycle after symbol 43 is accepted.
- Deinterleave round-trip: feed the interleaved sequence above with mode 1 -> outputs 0..43 in order; out_mode = 1 throughout.
- Back-pressure: out_ready = 0, stream 3 blocks -> in_ready drops after 88 accepted symbols. Release out_ready -> 132 outputs in correct per-block order, with no loss or duplication.
- Random valid/ready stalls: ROWS=3, COLS=5, 1000 blocks, random mode per block -> scoreboard via perm_idx matches. Mode toggled mid-block does not alter the captured mode.
- Reset mid-operation: assert rst after 20 symbols of block 1 while block 0 is draining at j=7 -> immediately out_valid = 0, in_ready = 1. A fresh block 0..43 afterwards is output correctly.
- Bit-level equivalence: SYM_W=1, random 44-bit words serialised LSB first, mode 0 -> serial output matches the existing combinational interleaver's output bit order.

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared constants and helpers for the streaming block interleaver.
// perm_idx is the plain-arithmetic output-to-input index map used by scoreboards.
package interleaver_pkg;

  localparam logic MODE_INT   = 1'b0;
  localparam logic MODE_DEINT = 1'b1;

  function automatic int block_len(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int perm_idx(input int j, input int rows, input int cols, input logic mode);
    if (mode == MODE_INT) return (j % rows) * cols + (j / rows);
    else                  return (j % cols) * rows + (j / cols);
  endfunction

endpackage

// File: rtl/il_addr_gen.sv
// Read-address generator: inner/outer wrap counters walking a ROWS x COLS matrix
// column-wise (interleave) or, with swap set, row-wise over the transposed fill.
module il_addr_gen #(
  parameter int ROWS = 4,
  parameter int COLS = 11,
  parameter int AW   = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          swap,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [AW-1:0] ROWS_M1 = AW'(ROWS - 1);
  localparam logic [AW-1:0] COLS_M1 = AW'(COLS - 1);
  localparam logic [AW-1:0] ROWS_W  = AW'(ROWS);
  localparam logic [AW-1:0] COLS_W  = AW'(COLS);

  logic [AW-1:0] inner;
  logic [AW-1:0] outer;
  logic [AW-1:0] inner_max;
  logic [AW-1:0] outer_max;
  logic [AW-1:0] stride;

  // NOTE: every always_comb output is assigned on every path, so no latch can form.
  always_comb begin
    inner_max = swap ? COLS_M1 : ROWS_M1;
    outer_max = swap ? ROWS_M1 : COLS_M1;
    stride    = swap ? ROWS_W  : COLS_W;
  end

  assign last = (inner == inner_max) && (outer == outer_max);

  // addr tracks inner*stride + outer incrementally, avoiding any runtime multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inner <= '0;
      outer <= '0;
      addr  <= '0;
    end else if (clr) begin
      inner <= '0;
      outer <= '0;
      addr  <= '0;
    end else if (en) begin
      if (inner == inner_max) begin
        inner <= '0;
        outer <= outer + AW'(1);
        addr  <= outer + AW'(1);
      end else begin
        inner <= inner + AW'(1);
        addr  <= addr + stride;
      end
    end
  end

endmodule

// File: rtl/block_interleaver_stream.sv
// Streaming ping-pong block (de)interleaver: row-major fill of one bank while the
// other is read back through a transposing address generator.
module block_interleaver_stream
  import interleaver_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 11,
  parameter int SYM_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_data,
  output logic             out_last,
  output logic             out_mode
);

  localparam int N  = block_len(ROWS, COLS);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_K = AW'(N - 1);

  logic [SYM_W-1:0] mem [2][N];
  logic [1:0]       full;
  logic [1:0]       bank_mode;
  logic             wr_sel;
  logic             rd_sel;
  logic [AW-1:0]    wr_cnt;
  logic [AW-1:0]    rd_addr;
  logic             rd_last;
  logic             wr_fire;
  logic             rd_fire;

  assign in_ready  = !full[wr_sel];
  assign wr_fire   = in_valid && in_ready;
  assign out_valid = full[rd_sel];
  assign rd_fire   = out_valid && out_ready;
  assign out_last  = out_valid && rd_last;
  assign out_data  = mem[rd_sel][rd_addr];
  assign out_mode  = bank_mode[rd_sel];

  // NOTE: storage has no reset; full flags alone decide whether contents are meaningful.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_sel][wr_cnt] <= in_data;
  end

  // Writer and reader never set and clear the same bank's full flag on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= '0;
      bank_mode <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_cnt    <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == '0) bank_mode[wr_sel] <= mode;
        if (wr_cnt == LAST_K) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
          wr_cnt       <= '0;
        end else begin
          wr_cnt <= wr_cnt + AW'(1);
        end
      end
      if (rd_fire && rd_last) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
    end
  end

  il_addr_gen #(
    .ROWS (ROWS),
    .COLS (COLS),
    .AW   (AW)
  ) u_rd_addr (
    .clk  (clk),
    .rst  (rst),
    .en   (rd_fire),
    .clr  (rd_fire && rd_last),
    .swap (bank_mode[rd_sel]),
    .addr (rd_addr),
    .last (rd_last)
  );

endmodule
